mlp_stream_loader: RTL and testbench

MLP_STREAM_LOADER -- requirements
Module: mlp_stream_loader

---
 rtl/mlp_pkg.sv | 34 +++
 rtl/mlp_phase_counter.sv | 28 ++
 rtl/mlp_stream_loader.sv | 182 ++++++++++++++++++
 tb/tb_mlp_stream_loader.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// Shared FSM state type, write-select encoding, default tile geometry and
// word-count helpers for the MLP stream loader.
package mlp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    IFMAP,
    WEIGHT,
    BIAS,
    DONE
  } state_t;

  localparam logic [1:0] SEL_IFMAP  = 2'd0;
  localparam logic [1:0] SEL_WEIGHT = 2'd1;
  localparam logic [1:0] SEL_BIAS   = 2'd2;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_LANES    = 4;
  localparam int DEF_TILE_IN  = 64;
  localparam int DEF_TILE_OUT = 64;

  function automatic int calc_ni(input int tile_in, input int lanes);
    return tile_in / lanes;
  endfunction

  function automatic int calc_nw(input int tile_out, input int ni);
    return tile_out * ni;
  endfunction

  function automatic int calc_nb(input int tile_out);
    return tile_out;
  endfunction

endpackage

// File: rtl/mlp_phase_counter.sv
// Loadable up-counter with a terminal-count flag; used both for the buffer
// word address and for the pass index.
module mlp_phase_counter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] last,
  output logic [W-1:0] count,
  output logic         tc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == last);

endmodule

// File: rtl/mlp_stream_loader.sv
// Streams one pass of ifmap, weight and bias words into the GLB buffers.
// Optional error monitor (err / err_cnt) is enabled by LOADER_ERR_CHECK_EN.
module mlp_stream_loader
  import mlp_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LANES      = DEF_LANES,
  parameter int TILE_IN    = DEF_TILE_IN,
  parameter int TILE_OUT   = DEF_TILE_OUT,
  parameter int MAX_PASSES = 2,
  localparam int BUS_W     = DATA_W * LANES,
  localparam int PASS_W    = (MAX_PASSES > 1) ? $clog2(MAX_PASSES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              ready,
  input  logic [BUS_W-1:0]  data_in,
  input  logic              data_vld,
  output logic              data_rdy,
  output logic              wr_en,
  output logic [1:0]        wr_sel,
  output logic [9:0]        wr_addr,
  output logic [BUS_W-1:0]  wr_data,
  output logic [PASS_W-1:0] pass_idx,
  output logic              busy,
  output logic              load_done,
  output logic              layer_done
`ifdef LOADER_ERR_CHECK_EN
  ,
  output logic              err,
  output logic [7:0]        err_cnt
`endif
);

  localparam int NI     = calc_ni(TILE_IN, LANES);
  localparam int NW     = calc_nw(TILE_OUT, NI);
  localparam int NB     = calc_nb(TILE_OUT);
  localparam int ADDR_W = 10;

  state_t            state;
  logic              mode_q;
  logic              accept;
  logic [1:0]        cur_sel;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_last;
  logic              addr_tc;
  logic [PASS_W-1:0] pass_cnt;
  logic              pass_tc;
  logic              last_pass;
  logic              in_done;

  assign accept    = data_vld && data_rdy;
  assign in_done   = (state == DONE);
  assign last_pass = !mode_q || pass_tc;
  assign pass_idx  = pass_cnt;

  always_comb begin
    cur_sel   = SEL_IFMAP;
    addr_last = '0;
    case (state)
      IFMAP: begin
        cur_sel   = SEL_IFMAP;
        addr_last = ADDR_W'(NI - 1);
      end
      WEIGHT: begin
        cur_sel   = SEL_WEIGHT;
        addr_last = ADDR_W'(NW - 1);
      end
      BIAS: begin
        cur_sel   = SEL_BIAS;
        addr_last = ADDR_W'(NB - 1);
      end
      default: ;
    endcase
  end

  // Address restarts at 0 on the last word of each buffer, so it is already
  // 0 when the next buffer (or the next pass) begins.
  mlp_phase_counter #(.W(ADDR_W)) u_addr_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept && addr_tc),
    .load_val ('0),
    .inc      (accept && !addr_tc),
    .last     (addr_last),
    .count    (addr),
    .tc       (addr_tc)
  );

  mlp_phase_counter #(.W(PASS_W)) u_pass_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (in_done && last_pass),
    .load_val ('0),
    .inc      (in_done && !last_pass),
    .last     (PASS_W'(MAX_PASSES - 1)),
    .count    (pass_cnt),
    .tc       (pass_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mode_q     <= 1'b0;
      busy       <= 1'b0;
      data_rdy   <= 1'b0;
      load_done  <= 1'b0;
      layer_done <= 1'b0;
      wr_en      <= 1'b0;
      wr_sel     <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      load_done  <= 1'b0;
      layer_done <= 1'b0;
      wr_en      <= accept;
      if (accept) begin
        wr_sel  <= cur_sel;
        wr_addr <= addr;
        wr_data <= data_in;
      end
      case (state)
        IDLE: begin
          if (ready) begin
            state    <= IFMAP;
            mode_q   <= mode;
            busy     <= 1'b1;
            data_rdy <= 1'b1;
          end
        end
        IFMAP: begin
          if (accept && addr_tc) state <= WEIGHT;
        end
        WEIGHT: begin
          if (accept && addr_tc) state <= BIAS;
        end
        BIAS: begin
          // DONE coincides with the registered write of the final bias word.
          if (accept && addr_tc) begin
            state      <= DONE;
            data_rdy   <= 1'b0;
            load_done  <= 1'b1;
            layer_done <= last_pass;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          data_rdy <= 1'b0;
        end
      endcase
    end
  end

`ifdef LOADER_ERR_CHECK_EN
  logic [1:0] err_events;
  logic [8:0] err_sum;

  // A stray ready and a stray data_vld in the same cycle count as two events.
  always_comb begin
    err_events = {1'b0, (ready && state != IDLE)} +
                 {1'b0, (data_vld && (state == IDLE || state == DONE))};
    err_sum    = {1'b0, err_cnt} + {7'd0, err_events};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (err_events != 2'd0) begin
      err     <= 1'b1;
      err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
    end
  end
`endif

endmodule

// File: tb/tb_mlp_stream_loader.sv
// Self-checking bench for mlp_stream_loader: lockstep behavioural model plus
// directed scenarios (stall, stray ready, mid-load reset, mode change).
module tb_mlp_stream_loader;

  localparam int DATA_W     = 8;
  localparam int LANES      = 4;
  localparam int TILE_IN    = 64;
  localparam int TILE_OUT   = 64;
  localparam int MAX_PASSES = 2;
  localparam int BUS_W      = DATA_W * LANES;
  localparam int PASS_W     = (MAX_PASSES > 1) ? $clog2(MAX_PASSES) : 1;
  localparam int NI         = TILE_IN / LANES;
  localparam int NW         = TILE_OUT * NI;
  localparam int NB         = TILE_OUT;
  localparam int TOTAL      = NI + NW + NB;
  localparam int LOAD_BOUND = 4000;

  localparam int PH_IDLE = 0;
  localparam int PH_LOAD = 1;
  localparam int PH_DONE = 2;

  localparam int SC_PLAIN     = 0;
  localparam int SC_COUNT     = 1;
  localparam int SC_STALL     = 2;
  localparam int SC_READY     = 3;
  localparam int SC_RESET     = 4;
  localparam int SC_MODE      = 5;
  localparam int SC_DONEREADY = 6;
  localparam int SC_RANDOM    = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic              mode;
  logic              ready;
  logic [BUS_W-1:0]  data_in;
  logic              data_vld;
  logic              data_rdy;
  logic              wr_en;
  logic [1:0]        wr_sel;
  logic [9:0]        wr_addr;
  logic [BUS_W-1:0]  wr_data;
  logic [PASS_W-1:0] pass_idx;
  logic              busy;
  logic              load_done;
  logic              layer_done;
`ifdef LOADER_ERR_CHECK_EN
  logic              err;
  logic [7:0]        err_cnt;
`endif

  int total;
  int bad;

  // reference model state
  int               m_phase;
  int               m_k;
  int               m_pass;
  logic             m_mode;
  logic             e_wr_en;
  logic [1:0]       e_sel;
  logic [9:0]       e_addr;
  logic [BUS_W-1:0] e_data;
  logic             e_load_done;
  logic             e_layer_done;
  logic             e_err;
  int               e_err_cnt;

  mlp_stream_loader #(
    .DATA_W     (DATA_W),
    .LANES      (LANES),
    .TILE_IN    (TILE_IN),
    .TILE_OUT   (TILE_OUT),
    .MAX_PASSES (MAX_PASSES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .ready      (ready),
    .data_in    (data_in),
    .data_vld   (data_vld),
    .data_rdy   (data_rdy),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .pass_idx   (pass_idx),
    .busy       (busy),
    .load_done  (load_done),
    .layer_done (layer_done)
`ifdef LOADER_ERR_CHECK_EN
    ,
    .err        (err),
    .err_cnt    (err_cnt)
`endif
  );

  initial forever #5 clk = ~clk;

  initial begin
    #(10 * 90000);
    $display("[TB] FAIL watchdog: observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // The model works on a flat word index within the pass: the buffer and
  // address of each word follow directly from where that index falls.
  task automatic modelStep();
    logic last;
    int   ev;
    last = (m_mode == 1'b0) || (m_pass == MAX_PASSES - 1);
    e_wr_en      = 1'b0;
    e_load_done  = 1'b0;
    e_layer_done = 1'b0;
    if (rst) begin
      m_phase   = PH_IDLE;
      m_k       = 0;
      m_pass    = 0;
      m_mode    = 1'b0;
      e_sel     = '0;
      e_addr    = '0;
      e_data    = '0;
      e_err     = 1'b0;
      e_err_cnt = 0;
    end else begin
      ev = 0;
      if (ready && m_phase != PH_IDLE) ev++;
      if (data_vld && (m_phase == PH_IDLE || m_phase == PH_DONE)) ev++;
      if (ev > 0) begin
        e_err     = 1'b1;
        e_err_cnt = (e_err_cnt + ev > 255) ? 255 : e_err_cnt + ev;
      end
      case (m_phase)
        PH_IDLE: begin
          if (ready) begin
            m_phase = PH_LOAD;
            m_k     = 0;
            m_mode  = mode;
          end
        end
        PH_LOAD: begin
          if (data_vld) begin
            e_wr_en = 1'b1;
            e_data  = data_in;
            if (m_k < NI) begin
              e_sel  = 2'd0;
              e_addr = 10'(m_k);
            end else if (m_k < NI + NW) begin
              e_sel  = 2'd1;
              e_addr = 10'(m_k - NI);
            end else begin
              e_sel  = 2'd2;
              e_addr = 10'(m_k - NI - NW);
            end
            m_k++;
            if (m_k == TOTAL) begin
              m_phase      = PH_DONE;
              e_load_done  = 1'b1;
              e_layer_done = last;
            end
          end
        end
        default: begin
          m_phase = PH_IDLE;
          m_pass  = last ? 0 : m_pass + 1;
        end
      endcase
    end
  endtask

  task automatic compareAll();
    checkOutput("wr_bus", 64'({wr_en, wr_sel, wr_addr, wr_data}),
                64'({e_wr_en, e_sel, e_addr, e_data}));
    checkOutput("ctrl", 64'({busy, data_rdy, load_done, layer_done, pass_idx}),
                64'({(m_phase != PH_IDLE), (m_phase == PH_LOAD), e_load_done,
                     e_layer_done, PASS_W'(m_pass)}));
`ifdef LOADER_ERR_CHECK_EN
    checkOutput("err", 64'({err, err_cnt}), 64'({e_err, 8'(e_err_cnt)}));
`endif
  endtask

  task automatic applyStimulus(input logic r, input logic m, input logic v,
                               input logic [BUS_W-1:0] d, input logic rs);
    @(negedge clk);
    ready    = r;
    mode     = m;
    data_vld = v;
    data_in  = d;
    rst      = rs;
    @(posedge clk);
    modelStep();
    #1;
    compareAll();
  endtask

  task automatic idleCycles(input int n, input bit rand_vld);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, mode, rand_vld ? 1'($urandom) : 1'b0, BUS_W'($urandom), 1'b0);
  endtask

  task automatic runLoad(input int scen, input logic start_mode, input int vld_pct,
                         output int done_cycle, output int layer_cnt);
    int               idx;
    int               stall;
    bit               pulsed;
    bit               captured;
    logic             r, m, v, rs;
    logic [BUS_W-1:0] d;
    idx = 0; stall = 0; pulsed = 0; captured = 0;
    done_cycle = -1; layer_cnt = 0;
    applyStimulus(1'b1, start_mode, 1'b0, '0, 1'b0);
    while (m_phase != PH_IDLE && idx < LOAD_BOUND) begin
      r  = 1'b0;
      m  = start_mode;
      rs = 1'b0;
      d  = (scen == SC_COUNT) ? BUS_W'(m_k) : BUS_W'($urandom);
      v  = (m_phase == PH_LOAD) && ($urandom_range(99) < vld_pct);
      case (scen)
        SC_STALL: if (m_k == NI + 501 && stall < 3) begin v = 1'b0; stall++; end
        SC_READY: if (m_k == NI + 200 && !pulsed) begin r = 1'b1; pulsed = 1; end
        SC_RESET: if (m_k == NI + NW + 10) rs = 1'b1;
        SC_MODE: if (m_k >= 300) m = ~start_mode;
        SC_DONEREADY: if (m_phase == PH_DONE) r = 1'b1;
        SC_RANDOM: begin
          r = ($urandom_range(31) == 0);
          m = 1'($urandom);
          v = ($urandom_range(99) < vld_pct);
        end
        default: ;
      endcase
      idx++;
      applyStimulus(r, m, v, d, rs);
      if (load_done && done_cycle < 0) done_cycle = idx + 1;
      if (layer_done) layer_cnt++;
      if (scen == SC_STALL && stall == 3 && !captured && wr_en) begin
        captured = 1;
        checkOutput("stall_next_addr", 64'(wr_addr), 64'(501));
      end
    end
    if (idx >= LOAD_BOUND) checkOutput("load_timeout_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    int dc, lc;
    total = 0; bad = 0;
    m_phase = PH_IDLE; m_k = 0; m_pass = 0; m_mode = 1'b0;
    e_wr_en = 1'b0; e_sel = '0; e_addr = '0; e_data = '0;
    e_load_done = 1'b0; e_layer_done = 1'b0; e_err = 1'b0; e_err_cnt = 0;
    rst = 1'b1; mode = 1'b0; ready = 1'b0; data_vld = 1'b0; data_in = '0;

    $display("[TB] reset");
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("reset_busy", 64'(busy), 64'(0));
    checkOutput("reset_wr_en", 64'(wr_en), 64'(0));
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);

    $display("[TB] mode 0 single pass, word index data");
    runLoad(SC_COUNT, 1'b0, 100, dc, lc);
    checkOutput("done_cycle", 64'(dc), 64'(TOTAL + 1));
    checkOutput("single_layer_done", 64'(lc), 64'(1));
    checkOutput("single_pass_idx", 64'(pass_idx), 64'(0));

    $display("[TB] mode 1 two passes, stall in second");
    runLoad(SC_PLAIN, 1'b1, 80, dc, lc);
    checkOutput("p0_layer_done", 64'(lc), 64'(0));
    checkOutput("p0_pass_idx", 64'(pass_idx), 64'(1));
    runLoad(SC_STALL, 1'b1, 100, dc, lc);
    checkOutput("p1_layer_done", 64'(lc), 64'(1));
    checkOutput("p1_pass_idx", 64'(pass_idx), 64'(0));

    $display("[TB] reset in bias");
    runLoad(SC_PLAIN, 1'b1, 90, dc, lc);
    runLoad(SC_RESET, 1'b1, 100, dc, lc);
    checkOutput("rst_wr_en", 64'(wr_en), 64'(0));
    checkOutput("rst_pass_idx", 64'(pass_idx), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    runLoad(SC_PLAIN, 1'b0, 100, dc, lc);
    checkOutput("post_rst_layer_done", 64'(lc), 64'(1));

    $display("[TB] stray ready in weight");
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    runLoad(SC_READY, 1'b0, 100, dc, lc);
    checkOutput("stray_ready_layer_done", 64'(lc), 64'(1));
`ifdef LOADER_ERR_CHECK_EN
    checkOutput("err_flag", 64'(err), 64'(1));
    checkOutput("err_cnt", 64'(err_cnt), 64'(1));
`endif

    $display("[TB] mode change mid-load");
    runLoad(SC_MODE, 1'b0, 100, dc, lc);
    checkOutput("mode_chg_layer_done", 64'(lc), 64'(1));
    runLoad(SC_PLAIN, 1'b1, 85, dc, lc);
    checkOutput("next_layer_p0", 64'(lc), 64'(0));
    runLoad(SC_PLAIN, 1'b1, 85, dc, lc);
    checkOutput("next_layer_p1", 64'(lc), 64'(1));

    $display("[TB] ready during DONE");
    runLoad(SC_DONEREADY, 1'b0, 100, dc, lc);
    idleCycles(2, 1'b0);
    checkOutput("done_ready_ignored", 64'(busy), 64'(0));

    $display("[TB] randomized passes");
    for (int i = 0; i < 3; i++) begin
      idleCycles(int'($urandom_range(5, 1)), 1'b1);
      runLoad(SC_RANDOM, 1'($urandom), 75, dc, lc);
    end
    idleCycles(3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
